// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings and constants for the sequential shift unit
//
// Purpose: op and FSM state encodings, operand width and per-cycle step limit,
// shared by shift_stage8 and shift_seq8.
package shift_pkg;

  localparam int WIDTH = 8;

  // Largest shift one stage pass can do (max value of a 2-bit shamt).
  localparam int MAX_STEP = 3;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Positions to shift this cycle: the remaining count, capped at MAX_STEP.
  function automatic logic [1:0] step_of(input logic [2:0] rem);
    return (rem > 3'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];
  endfunction

endpackage

// File: rtl/shift_stage8.sv
// rtl/shift_stage8.sv - combinational 8-bit shifter, shift by 0..3
//
// Purpose: one pass of the iterative shifter. Each output bit is a 4:1 mux
// indexed by shamt; each mux leg selects the bit that lands there for the
// current op.
// Ports:
//   d_in  [7:0] operand
//   op    [1:0] OP_LSR / OP_LSL / OP_ASR / OP_ROR
//   shamt [1:0] shift distance 0..3
//   d_out [7:0] shifted result
// Config: SHIFT_SEQ8_ROTATE_EN adds the rotate-right leg; without it op=11
// falls through to logical shift right.
module shift_stage8
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       op,
  input  logic [1:0]       shamt,
  output logic [WIDTH-1:0] d_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [3:0] leg;

    for (genvar k = 0; k < 4; k++) begin : g_leg
      logic lsr_b;
      logic lsl_b;
      logic asr_b;

      // Right shifts read from bit i+k; past the MSB, LSR fills zero and
      // ASR fills with the sign bit.
      if (i + k <= WIDTH - 1) begin : g_in_range_r
        assign lsr_b = d_in[i+k];
        assign asr_b = d_in[i+k];
      end else begin : g_fill_r
        assign lsr_b = 1'b0;
        assign asr_b = d_in[WIDTH-1];
      end

      if (i - k >= 0) begin : g_in_range_l
        assign lsl_b = d_in[i-k];
      end else begin : g_fill_l
        assign lsl_b = 1'b0;
      end

`ifdef SHIFT_SEQ8_ROTATE_EN
      logic ror_b;
      assign ror_b  = d_in[(i+k)%WIDTH];
      assign leg[k] = (op == OP_LSL) ? lsl_b :
                      (op == OP_ASR) ? asr_b :
                      (op == OP_ROR) ? ror_b : lsr_b;
`else
      assign leg[k] = (op == OP_LSL) ? lsl_b :
                      (op == OP_ASR) ? asr_b : lsr_b;
`endif
    end

    assign d_out[i] = leg[shamt];
  end

endmodule

// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - multi-cycle 8-bit shifter, up to 3 positions per cycle
//
// Purpose: latches an operand and a 0..7 shift amount, then runs it through
// shift_stage8 once per cycle until the requested amount is used up. The
// result sits in d_out with a one-cycle done pulse.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request, sampled only in IDLE
//   op[1:0]  00 LSR, 01 LSL, 10 ASR, 11 ROR (or LSR when rotate disabled)
//   amount   total shift 0..7
//   d_in     operand
//   busy     high in SHIFT and DONE
//   done     one-cycle result-valid pulse
//   d_out    result register
// Config: SHIFT_SEQ8_ROTATE_EN enables op=11 as rotate right (in shift_stage8).
module shift_seq8
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       amount,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  state_e           state;
  logic [2:0]       rem;
  logic [1:0]       op_r;
  logic [1:0]       step;
  logic [2:0]       rem_next;
  logic [WIDTH-1:0] stage_out;

  assign step     = step_of(rem);
  assign rem_next = rem - {1'b0, step};

  shift_stage8 u_stage (
    .d_in  (d_out),
    .op    (op_r),
    .shamt (step),
    .d_out (stage_out)
  );

  // busy/done are registered alongside the state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d_out <= '0;
      rem   <= '0;
      op_r  <= OP_LSR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            d_out <= d_in;
            rem   <= amount;
            op_r  <= op;
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        // amount=0 still takes one pass here with step 0.
        ST_SHIFT: begin
          d_out <= stage_out;
          rem   <= rem_next;
          if (rem_next == 3'd0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// tb/tb_shift_seq8.sv - self-checking bench for shift_seq8
module tb_shift_seq8;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] amount;
  logic [7:0] d_in;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  int tests;
  int fails;

  shift_seq8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .d_in    (d_in),
    .busy    (busy),
    .done    (done),
    .d_out   (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-amount shift done in one go with plain operators.
  function automatic logic [7:0] model(input logic [1:0] o, input int a, input logic [7:0] x);
    logic [7:0] r;
    case (o)
      2'b01:   r = x << a;
      2'b10:   r = 8'($signed(x) >>> a);
`ifdef SHIFT_SEQ8_ROTATE_EN
      2'b11:   r = (x >> a) | (x << (8 - a));
`endif
      default: r = x >> a;
    endcase
    return r;
  endfunction

  // Edges from the accept edge (counted as 1) until done is visible.
  function automatic int model_lat(input int a);
    return (a == 0) ? 2 : 1 + (a + 2) / 3;
  endfunction

  // Run one operation; while busy, inputs (including start) are scrambled.
  task automatic do_op(input logic [1:0] o, input logic [2:0] a, input logic [7:0] x,
                       input logic [7:0] exp, input int lat, input string tag);
    int edges;
    bit seen;
    @(negedge clk);
    op = o; amount = a; d_in = x; start = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start  = 1'($urandom_range(0, 1));
      op     = 2'($urandom_range(0, 3));
      amount = 3'($urandom_range(0, 7));
      d_in   = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        break;
      end
      @(posedge clk);
      edges++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within budget", tag);
      start = 1'b0;
      return;
    end
    chk({tag, " latency"}, edges, lat);
    chk({tag, " d_out"}, d_out, exp);
    @(negedge clk);
    chk({tag, " done pulse/idle"}, {done, busy}, 2'b00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; amount = 3'd0; d_in = 8'h00;

    vecs[0] = '{2'b00, 3'd7, 8'hFF, 8'h01, 4};
    vecs[1] = '{2'b10, 3'd5, 8'h80, 8'hFC, 3};
    vecs[2] = '{2'b10, 3'd5, 8'h40, 8'h02, 3};
    vecs[3] = '{2'b01, 3'd0, 8'hA5, 8'hA5, 2};
    vecs[4] = '{2'b01, 3'd3, 8'h81, 8'h08, 2};
    vecs[5] = '{2'b00, 3'd4, 8'hF0, 8'h0F, 3};
`ifdef SHIFT_SEQ8_ROTATE_EN
    vecs[6] = '{2'b11, 3'd4, 8'h12, 8'h21, 3};
`else
    vecs[6] = '{2'b11, 3'd4, 8'h12, 8'h01, 3};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset d_out", d_out, 8'h00);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp, vecs[i].lat,
                            $sformatf("vec%0d", i));

    // Reset during SHIFT abandons the operation
    begin
      bit saw_done;
      @(negedge clk);
      op = 2'b00; amount = 3'd7; d_in = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      saw_done = done;
      @(negedge clk);
      chk("midreset busy", busy, 0);
      chk("midreset d_out", d_out, 8'h00);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        saw_done |= done;
      end
      chk("midreset no done", saw_done, 0);
    end

    // start held high: accept, 2 SHIFT, DONE, accept again -> done every 4th cycle
    @(negedge clk);
    op = 2'b00; amount = 3'd4; d_in = 8'hF0; start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("b2b done c%0d", c), done, (c % 4 == 2) ? 1 : 0);
      if (done) chk($sformatf("b2b d_out c%0d", c), d_out, 8'h0F);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b idle", busy, 0);

    // Randomized against the arithmetic model
    for (int n = 0; n < 150; n++) begin
      logic [1:0] o;
      logic [2:0] a;
      logic [7:0] x;
      o = 2'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      x = 8'($urandom_range(0, 255));
      do_op(o, a, x, model(o, int'(a), x), model_lat(int'(a)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
